pila_retorno: RTL and testbench
===============================

Name: pila_retorno

Overview:
- Hardware return-address stack (LIFO) for the CPU datapath; sits directly downstream of the control unit.
- Consumes the control unit's push/pop strobes and the return address from the PC incrementer.
- Drives the top-of-stack address into the PC next-address mux, selected when s_pila=1.
- Supports subroutine call/return; reports full/empty and sticky overflow/underflow errors.

Parameters:
ADDR_W, 10, width of program-counter addresses stored per entry
DEPTH, 8, number of stack entries (any value >= 2; power of two not required)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset
push  input  1  from control unit: store d_in on top of stack this cycle
pop  input  1  from control unit: remove top entry this cycle
d_in  input  ADDR_W  return address to save (PC+1 from incrementer)
d_out  output  ADDR_W  current top-of-stack entry, to PC mux
count  output  $clog2(DEPTH+1)  number of valid entries
empty  output  1  count==0
full  output  1  count==DEPTH
overflow  output  1  sticky: push attempted while full
underflow  output  1  sticky: pop attempted while empty

Behaviour:
- Reset (reset=0, asynchronous, takes effect immediately regardless of clk):
  - sp/count=0; all storage entries=0; overflow=0; underflow=0.
  - Resulting outputs: empty=1, full=0, d_out=0.
  - A reset asserted mid-sequence discards all entries.
- Storage and read:
  - DEPTH x ADDR_W register array, synchronous write, combinational read.
  - d_out = entry[count-1] when count>0; d_out=0 when empty.
  - Read latency 0: in the same cycle the control unit asserts pop with s_pila=1, d_out already holds the return address, so the PC loads it at that rising edge.
- Push only (push=1, pop=0):
  - Not full: entry[count] <= d_in; count <= count+1. New value appears on d_out the cycle after the edge.
  - Full: no write, count unchanged, overflow <= 1.
- Pop only (push=0, pop=1):
  - Not empty: count <= count-1. Popped slot contents are don't-care afterwards; they need not be cleared.
  - Empty: count unchanged, d_out stays 0, underflow <= 1.
- Push and pop together:
  - Not empty: replace top. entry[count-1] <= d_in; count unchanged; d_out shows the old top during that cycle. Applies when full as well, with no overflow.
  - Empty: treated as push only; underflow not set.
- Neither asserted: state holds.
- Error flags: overflow and underflow are sticky and cleared only by reset. Neither flag blocks further operation.
- Width rules:
  - count saturates at 0 and DEPTH; it never wraps.
  - Pointer arithmetic uses count width; index count-1 is only evaluated when count>0.
- No internal FSM beyond the count register. All outputs derive from count, storage and the flags, with no extra pipeline stage.

Decomposition:
- Shared CPU package/header: ADDR_W (PC width, shared with PC register, incrementer and instruction memory); opcode constants for push (100100) and pop (100101) for bench use.
- One natural sub-module: pila_mem, the DEPTH x ADDR_W register array with write enable, write index and combinational read index.
- pila_retorno holds count, flags and the push/pop decode.

Test Plan:
- Reset then idle -> empty=1, full=0, count=0, d_out=0, overflow=0, underflow=0. Assert reset mid-stack after 3 pushes -> count=0 and d_out=0 immediately, without waiting for a clock edge.
- Push 0x005, 0x012, 0x3FF on consecutive cycles -> count=3, d_out=0x3FF. Pop three times -> d_out reads 0x3FF, 0x012, 0x005 in the pop cycles; then empty=1.
- Push 8 values 0x100..0x107 (DEPTH=8) -> full=1, d_out=0x107. 9th push of 0x1FF -> count stays 8, d_out=0x107, overflow=1 and remains 1 after later pops.
- From empty, pop -> underflow=1, count=0, d_out=0. Then push 0x020 -> count=1, d_out=0x020, underflow still 1.
- Stack holds 0x010, 0x011; push=pop=1 with d_in=0x0AA -> d_out=0x011 during the cycle, then count=2, d_out=0x0AA. Same stimulus when empty with d_in=0x0BB -> count=1, d_out=0x0BB, underflow=0.
- Call/return chain with control unit: push PC+1=0x004, then push 0x009, then pop with s_pila=1 -> PC mux receives 0x009 in the pop cycle; second pop -> 0x004.

Source files
------------

// File: rtl/pila_retorno_pkg.sv
// Shared CPU constants: program-counter width and the call/return opcodes
// that the control unit decodes into push/pop strobes.
package pila_retorno_pkg;

  // Width of program-counter addresses (PC register, incrementer, imem, stack)
  localparam int PC_ADDR_W = 10;

  // Opcodes that the control unit turns into stack strobes
  localparam logic [5:0] OP_PUSH = 6'b100100;
  localparam logic [5:0] OP_POP  = 6'b100101;

endpackage

// File: rtl/pila_retorno_if.sv
// Control-unit <-> return-stack bundle: strobes and return address in,
// top-of-stack and status out.
interface pila_retorno_if #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 8
) ();

  localparam int CW = $clog2(DEPTH + 1);

  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] d_in;
  logic [ADDR_W-1:0] d_out;
  logic [CW-1:0]     count;
  logic              empty;
  logic              full;
  logic              overflow;
  logic              underflow;

  // Control unit side
  modport master (
    output push, pop, d_in,
    input  d_out, count, empty, full, overflow, underflow
  );

  // Stack side
  modport slave (
    input  push, pop, d_in,
    output d_out, count, empty, full, overflow, underflow
  );

endinterface

// File: rtl/pila_retorno_mem.sv
// DEPTH x ADDR_W register array: one synchronous write port and one
// combinational read port, cleared by the asynchronous reset.
module pila_mem
#(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 8,
  localparam int IW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [IW-1:0]     wr_idx,
  input  logic [ADDR_W-1:0] wr_data,
  input  logic [IW-1:0]     rd_idx,
  output logic [ADDR_W-1:0] rd_data
);

  logic [ADDR_W-1:0] mem [DEPTH];

  // Storage write; every entry is cleared while reset is low
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[wr_idx] <= wr_data;
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/pila_retorno.sv
// Return-address stack (LIFO) feeding the PC next-address mux. Holds the
// entry count, the sticky error flags and the push/pop decode; storage
// lives in pila_mem. The top of stack is visible with zero latency.
module pila_retorno
  import pila_retorno_pkg::*;
#(
  parameter int ADDR_W = PC_ADDR_W,
  parameter int DEPTH  = 8
) (
  input  logic          clk,
  input  logic          reset,
  pila_retorno_if.slave bus
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);

  logic [CW-1:0]     count_q;
  logic [CW-1:0]     count_nxt;
  logic              ovf_q;
  logic              unf_q;
  logic              ovf_set;
  logic              unf_set;
  logic              we;
  logic [IW-1:0]     wr_idx;
  logic [IW-1:0]     rd_idx;
  logic [ADDR_W-1:0] rd_data;
  logic              empty_w;
  logic              full_w;

  assign empty_w = (count_q == '0);
  assign full_w  = (count_q == CW'(DEPTH));

  // Top index only formed when the stack holds something, so count-1 never wraps
  assign rd_idx = empty_w ? '0 : IW'(count_q - CW'(1));

  // Push/pop decode: next count, write port and error-flag set requests
  always_comb begin
    count_nxt = count_q;
    we        = 1'b0;
    wr_idx    = '0;
    ovf_set   = 1'b0;
    unf_set   = 1'b0;
    unique case ({bus.push, bus.pop})
      2'b10: begin
        if (full_w) begin
          ovf_set = 1'b1;
        end else begin
          we        = 1'b1;
          wr_idx    = IW'(count_q);
          count_nxt = count_q + CW'(1);
        end
      end
      2'b01: begin
        if (empty_w) begin
          unf_set = 1'b1;
        end else begin
          count_nxt = count_q - CW'(1);
        end
      end
      2'b11: begin
        // Simultaneous push/pop replaces the top; on an empty stack it is a plain push
        we = 1'b1;
        if (empty_w) begin
          wr_idx    = '0;
          count_nxt = CW'(1);
        end else begin
          wr_idx = rd_idx;
        end
      end
      default: begin
      end
    endcase
  end

  // Count register and sticky error flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_nxt;
      if (ovf_set) ovf_q <= 1'b1;
      if (unf_set) unf_q <= 1'b1;
    end
  end

  pila_mem #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .reset   (reset),
    .we      (we),
    .wr_idx  (wr_idx),
    .wr_data (bus.d_in),
    .rd_idx  (rd_idx),
    .rd_data (rd_data)
  );

  assign bus.d_out     = empty_w ? '0 : rd_data;
  assign bus.count     = count_q;
  assign bus.empty     = empty_w;
  assign bus.full      = full_w;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;

endmodule

// File: tb/tb_pila_retorno.sv
// Scoreboard bench for pila_retorno: stimulus queues the expected outputs
// for the current cycle, a negedge monitor pops and compares them.
module tb_pila_retorno;
  import pila_retorno_pkg::*;

  localparam int AW = 10;
  localparam int DP = 8;

  typedef struct {
    string     name;
    logic [AW-1:0] d;
    logic [3:0] c;
    logic      e;
    logic      f;
    logic      o;
    logic      u;
  } exp_t;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  exp_t sb[$];

  pila_retorno_if #(.ADDR_W(AW), .DEPTH(DP)) bus ();

  pila_retorno #(.ADDR_W(AW), .DEPTH(DP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Queue the values the DUT must show before the next rising edge
  task automatic chk(input string name, input logic [AW-1:0] d, input logic [3:0] c,
                     input logic e, input logic f, input logic o, input logic u);
    exp_t x;
    x.name = name; x.d = d; x.c = c; x.e = e; x.f = f; x.o = o; x.u = u;
    sb.push_back(x);
  endtask

  // Apply one cycle of strobes, just after the rising edge
  task automatic step(input logic p, input logic q, input logic [AW-1:0] d);
    @(posedge clk);
    #1;
    bus.push = p;
    bus.pop  = q;
    bus.d_in = d;
  endtask

  // Control-unit style: decode an opcode into the stack strobes
  task automatic issue_op(input logic [5:0] op, input logic [AW-1:0] d);
    step(op == OP_PUSH, op == OP_POP, d);
  endtask

  // Assert reset between clock edges; outputs must clear before any edge
  task automatic reset_pulse(input string name);
    @(posedge clk);
    #1;
    bus.push = 1'b0;
    bus.pop  = 1'b0;
    reset    = 1'b0;
    chk(name, '0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    reset = 1'b1;
  endtask

  // Monitor: compare every queued expectation against the live outputs
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t x;
      x = sb.pop_front();
      total++;
      if (bus.d_out !== x.d || bus.count !== x.c || bus.empty !== x.e ||
          bus.full !== x.f || bus.overflow !== x.o || bus.underflow !== x.u) begin
        bad++;
        $display("FAIL %s: got d_out=%h count=%0d empty=%b full=%b ovf=%b unf=%b, want d_out=%h count=%0d empty=%b full=%b ovf=%b unf=%b",
                 x.name, bus.d_out, bus.count, bus.empty, bus.full, bus.overflow, bus.underflow,
                 x.d, x.c, x.e, x.f, x.o, x.u);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    total    = 0;
    bad      = 0;
    reset    = 1'b0;
    bus.push = 1'b0;
    bus.pop  = 1'b0;
    bus.d_in = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    chk("reset_idle", '0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);

    // LIFO order
    step(1'b1, 1'b0, 10'h005);
    step(1'b1, 1'b0, 10'h012);
    step(1'b1, 1'b0, 10'h3FF);
    step(1'b0, 1'b0, '0);
    chk("push3", 10'h3FF, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, '0);
    chk("pop_3ff", 10'h3FF, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, '0);
    chk("pop_012", 10'h012, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, '0);
    chk("pop_005", 10'h005, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0);
    chk("empty_after_pops", '0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Fill and overflow
    for (int i = 0; i < DP; i++) step(1'b1, 1'b0, AW'(10'h100 + i));
    step(1'b0, 1'b0, '0);
    chk("full", 10'h107, 4'd8, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 10'h1FF);
    step(1'b0, 1'b0, '0);
    chk("overflow", 10'h107, 4'd8, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, '0);
    step(1'b0, 1'b1, '0);
    chk("pop_after_ovf", 10'h106, 4'd7, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, '0);
    chk("ovf_sticky", 10'h105, 4'd6, 1'b0, 1'b0, 1'b1, 1'b0);
    reset_pulse("reset_clears_ovf");

    // Underflow
    step(1'b0, 1'b1, '0);
    step(1'b0, 1'b0, '0);
    chk("underflow", '0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 10'h020);
    step(1'b0, 1'b0, '0);
    chk("push_after_unf", 10'h020, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    reset_pulse("reset_clears_unf");

    // Replace top
    step(1'b1, 1'b0, 10'h010);
    step(1'b1, 1'b0, 10'h011);
    step(1'b1, 1'b1, 10'h0AA);
    chk("replace_cycle", 10'h011, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0);
    chk("replace_done", 10'h0AA, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < DP - 2; i++) step(1'b1, 1'b0, AW'(10'h200 + i));
    step(1'b1, 1'b1, 10'h2EE);
    chk("replace_full_cycle", 10'h205, 4'd8, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0);
    chk("replace_full", 10'h2EE, 4'd8, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, '0);
    step(1'b0, 1'b0, '0);
    chk("below_replaced", 10'h204, 4'd7, 1'b0, 1'b0, 1'b0, 1'b0);
    reset_pulse("reset_after_replace");
    step(1'b1, 1'b1, 10'h0BB);
    step(1'b0, 1'b0, '0);
    chk("replace_empty", 10'h0BB, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    reset_pulse("reset_after_empty_replace");

    // Reset mid-stack
    step(1'b1, 1'b0, 10'h111);
    step(1'b1, 1'b0, 10'h222);
    step(1'b1, 1'b0, 10'h333);
    step(1'b0, 1'b0, '0);
    chk("pre_reset_stack", 10'h333, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    reset_pulse("reset_mid_stack");
    step(1'b0, 1'b0, '0);
    chk("post_reset_idle", '0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Call/return chain driven by opcodes
    issue_op(OP_PUSH, 10'h004);
    issue_op(OP_PUSH, 10'h009);
    issue_op(OP_POP, '0);
    chk("ret_009", 10'h009, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    issue_op(OP_POP, '0);
    chk("ret_004", 10'h004, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0);
    chk("ret_empty", '0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: pending=%0d want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
